// File: rtl/link_table_order_master.sv
// Order initiator for link_table_mamager: FIFO-buffered host commands, one order in flight, tagged results.
// Latency: command accepted in cycle t -> order_valid at t+2; dout transfer -> res_valid next cycle.
// Backpressure: cmd_busy when FIFO full or halted; order_busy/res_busy hold outputs stable; watchdog halts on hung manager.

module link_table_order_master_fifo #(
  parameter int DW = 8,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [DW-1:0] i_dat,
  input  logic          i_pop,
  output logic [DW-1:0] o_dat,
  output logic          o_full,
  output logic          o_empty
);
  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_cnt;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign o_full    = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty   = (r_cnt == '0);
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;
  assign o_dat     = r_mem[r_rp];

  // Storage; cleared on reset so the head never presents stale or unknown data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push_ok) begin
      r_mem[r_wp] <= i_dat;
    end
  end

  // Read/write pointers and occupancy count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push_ok) r_wp <= r_wp + AW'(1);
      if (w_pop_ok)  r_rp <= r_rp + AW'(1);
      if (w_push_ok && !w_pop_ok)      r_cnt <= r_cnt + (AW+1)'(1);
      else if (!w_push_ok && w_pop_ok) r_cnt <= r_cnt - (AW+1)'(1);
    end
  end
endmodule

module link_table_order_master #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 16,
  parameter int TABLE_WIDTH    = 8,
  parameter int FIFO_AW        = 2,
  parameter int TAG_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_cmd_valid,
  output logic                   o_cmd_busy,
  input  logic [1:0]             i_cmd_type,
  input  logic [TABLE_WIDTH-1:0] i_cmd_table,
  input  logic [ADDR_WIDTH-1:0]  i_cmd_node,
  input  logic [DATA_WIDTH-1:0]  i_cmd_data,
  output logic                   o_order_valid,
  input  logic                   i_order_busy,
  output logic [1:0]             o_order_type,
  output logic [TABLE_WIDTH-1:0] o_order_table,
  output logic [ADDR_WIDTH-1:0]  o_order_node,
  output logic [DATA_WIDTH-1:0]  o_order_data,
  input  logic                   i_dout_valid,
  output logic                   o_dout_busy,
  input  logic [DATA_WIDTH-1:0]  i_dout_data,
  output logic                   o_res_valid,
  input  logic                   i_res_busy,
  output logic [TAG_WIDTH-1:0]   o_res_tag,
  output logic [1:0]             o_res_type,
  output logic [1:0]             o_res_status,
  output logic [DATA_WIDTH-1:0]  o_res_data,
  output logic                   o_halted
);
  localparam int CW = 2 + TABLE_WIDTH + ADDR_WIDTH + DATA_WIDTH;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_RESP  = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_FAIL    = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] T_READ     = 2'b11;

  logic [2:0]            r_state;
  logic                  r_order_vld;
  logic                  r_dout_busy;
  logic                  r_res_vld;
  logic [TAG_WIDTH-1:0]  r_tag;
  logic [1:0]            r_type;
  logic [1:0]            r_res_status;
  logic [DATA_WIDTH-1:0] r_res_data;
  logic                  r_halted;
  logic [TW-1:0]         r_timer;

  logic                   w_push;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_empty;
  logic [CW-1:0]          w_cmd_dat;
  logic [CW-1:0]          w_head;
  logic [1:0]             w_head_type;
  logic [TABLE_WIDTH-1:0] w_head_table;
  logic [ADDR_WIDTH-1:0]  w_head_node;
  logic [DATA_WIDTH-1:0]  w_head_data;
  logic                   w_order_xfer;
  logic                   w_dout_xfer;
  logic                   w_timeout;
  logic [1:0]             w_dout_status;

  assign o_cmd_busy = w_full || r_halted;
  assign w_push     = i_cmd_valid && !o_cmd_busy;
  assign w_cmd_dat  = {i_cmd_type, i_cmd_table, i_cmd_node, i_cmd_data};

  link_table_order_master_fifo #(
    .DW (CW),
    .AW (FIFO_AW)
  ) u_cmd_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_dat   (w_cmd_dat),
    .i_pop   (w_pop),
    .o_dat   (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign {w_head_type, w_head_table, w_head_node, w_head_data} = w_head;

  // The head entry is popped only once the manager takes it, so order_* stays stable while presented
  assign w_order_xfer = r_order_vld && !i_order_busy;
  assign w_pop        = (r_state == S_ISSUE) && w_order_xfer;
  assign w_dout_xfer  = i_dout_valid && !r_dout_busy;
  assign w_timeout    = (r_timer == TW'(TIMEOUT_CYCLES - 1));

  // READ always succeeds; list ops report a zero response as failure
  assign w_dout_status = (r_type == T_READ) ? ST_OK :
                         ((i_dout_data == '0) ? ST_FAIL : ST_OK);

  // Order fields are zero whenever no order is offered
  assign o_order_valid = r_order_vld;
  assign o_order_type  = r_order_vld ? w_head_type  : '0;
  assign o_order_table = r_order_vld ? w_head_table : '0;
  assign o_order_node  = r_order_vld ? w_head_node  : '0;
  assign o_order_data  = r_order_vld ? w_head_data  : '0;

  assign o_dout_busy  = r_dout_busy;
  assign o_res_valid  = r_res_vld;
  assign o_res_tag    = r_tag;
  assign o_res_type   = r_type;
  assign o_res_status = r_res_status;
  assign o_res_data   = r_res_data;
  assign o_halted     = r_halted;

  // Order sequencer: issue one order, wait for its response or the watchdog, deliver the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_order_vld  <= 1'b0;
      r_dout_busy  <= 1'b1;
      r_res_vld    <= 1'b0;
      r_tag        <= '0;
      r_type       <= '0;
      r_res_status <= '0;
      r_res_data   <= '0;
      r_halted     <= 1'b0;
      r_timer      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_state     <= S_ISSUE;
            r_order_vld <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (w_order_xfer) begin
            r_order_vld <= 1'b0;
            r_type      <= w_head_type;
            r_timer     <= '0;
            r_dout_busy <= 1'b0;
            r_state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_timer <= r_timer + TW'(1);
          // A response arriving in the last watchdog cycle still counts as a normal result
          if (w_dout_xfer) begin
            r_dout_busy  <= 1'b1;
            r_res_data   <= i_dout_data;
            r_res_status <= w_dout_status;
            r_res_vld    <= 1'b1;
            r_state      <= S_RESP;
          end else if (w_timeout) begin
            r_dout_busy  <= 1'b1;
            r_res_data   <= '0;
            r_res_status <= ST_TIMEOUT;
            r_res_vld    <= 1'b1;
            r_halted     <= 1'b1;
            r_state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (!i_res_busy) begin
            r_res_vld <= 1'b0;
            r_tag     <= r_tag + TAG_WIDTH'(1);
            if (r_halted) begin
              r_state     <= S_HALT;
              r_dout_busy <= 1'b0;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_HALT: begin
          // Soak up any late response from the hung manager; only reset leaves this state
          r_dout_busy <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
